uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx transmitter among NUM_CH byte producers (sensor channels).
//  Round-robin arbiter plus sequencer: grants one requester and captures its byte.
//  Optionally emits a channel tag byte, then the payload byte, over the uart_tx valid/ready port.
//  Sits between the sensor front-ends and uart_tx; the host demuxes channels by tag.
// PARAMETERS
//  DATA_WIDTH  8      byte width; must equal the uart_tx DATA_WIDTH
//  NUM_CH      4      number of requesters, 1..16
//  TAG_EN      1      1: send tag byte before each payload; 0: payload only
//  TAG_BASE    8'hF0  tag = TAG_BASE | ch; low CH_W bits of TAG_BASE must be 0
//  (derived)   CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1
// PORTS
//  clk        in   1                  system clock
//  rstn       in   1                  asynchronous active-low reset
//  req_valid  in   NUM_CH             per-channel byte available
//  req_data   in   NUM_CH*DATA_WIDTH  ch i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready  out  NUM_CH             one-hot accept strobe; byte taken when valid&ready
//  tx_data    out  DATA_WIDTH         byte to uart_tx (txif.data)
//  tx_valid   out  1                  byte offered to uart_tx (txif.valid)
//  tx_ready   in   1                  uart_tx idle/accepting (txif.ready)
//  busy       out  1                  1 in any state other than IDLE
//  cur_ch     out  CH_W               channel being served; last served when idle
//  frame_cnt  out  16                 completed payload bytes, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, tx_valid=0, tx_data=0, req_ready=0, busy=0,
//   cur_ch=0, rr_ptr=0, frame_cnt=0. Takes effect immediately, including mid-frame.
//   No partial tag/payload resumes after reset; the held byte is discarded.
//  FSM: IDLE -> TAG (TAG_EN=1) or DATA (TAG_EN=0) -> IDLE.
//  IDLE: winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
//   req_ready[winner]=1 combinationally in that cycle only; all other req_ready bits are 0.
//   On that edge: hold_data<=req_data[winner], cur_ch<=winner, busy<=1.
//   Also tx_data<=tag (or payload if TAG_EN=0), tx_valid<=1.
//   No req_valid: stay IDLE, outputs unchanged, tx_valid=0.
//  req_ready is 0 in every state except IDLE. Requesters hold valid+data until accepted.
//  TAG: tx_valid=1, tx_data=TAG_BASE|cur_ch. On tx_valid&tx_ready: tx_data<=hold_data -> DATA.
//  DATA: tx_valid=1, tx_data=hold_data. On tx_valid&tx_ready: tx_valid<=0, busy<=0,
//   frame_cnt<=frame_cnt+1, rr_ptr<=(cur_ch==NUM_CH-1)?0:cur_ch+1 -> IDLE.
//  tx_valid/tx_data are registered and stable while tx_valid=1 and tx_ready=0.
//  tx_ready already 1 on entry to TAG/DATA: the transfer occurs in that first cycle.
//  Latency: req accept edge -> tx_valid=1 next cycle. After the payload transfer,
//   IDLE lasts >=1 cycle, so there is at least 1 idle cycle between frames.
//  uart_tx drops ready while shifting, so a new byte is offered only after the stop bit.
//  Fairness: each of N continuously requesting channels is served once per N frames.
//  NUM_CH=1: rr_ptr stays 0; the single channel is served back-to-back.
//  req_valid deasserted by a non-granted channel before its turn: no effect, no error.
//  frame_cnt wraps 16'hFFFF -> 16'h0000 without saturation.
// TESTING
//  (Bench: DUT + uart_tx, DATA_WIDTH=8, BAUD 115200, CLK 100 MHz; decode sig at mid-bit.)
//  T1 single: ch2 valid, data 8'h5A -> req_ready[2] 1 cycle; line F2 then 5A; frame_cnt=1.
//  T2 round-robin: all 4 valid (11,22,33,44) continuously -> F0 11 F1 22 F2 33 F3 44 F0 11.
//  T3 skip: rr_ptr=1, only ch0 and ch3 valid -> ch3 served first, then ch0.
//  T4 TAG_EN=0, ch1 8'hA5 then ch1 8'h3C -> line A5, 3C; no tag bytes.
//  T5 tx_ready held 0 for 500 cycles in TAG -> tx_valid and tx_data=F<ch> stable, no loss.
//  T6 rstn low mid-DATA -> outputs at reset values same cycle; next frame after release correct.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer that shares one uart_tx among NUM_CH byte producers, optionally tagging each payload with its channel.
// Latency: request accepted on edge N, first byte (tag or payload) offered with tx_valid=1 from cycle N+1; at least one IDLE cycle between frames.
// Backpressure: tx_valid/tx_data held stable while tx_ready=0; req_ready is only raised in IDLE, so requesters hold valid+data until granted.
module uart_tx_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_CH     = 4,
  parameter bit                    TAG_EN     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] TAG_BASE   = 'hF0,
  localparam int                   CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]        tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic [CH_W-1:0]              cur_ch,
  output logic [15:0]                  frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [CH_W:0]   NUM_CH_V = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  state_t                  state_q, state_n;
  logic                    tx_valid_q, tx_valid_n;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_n;
  logic [DATA_WIDTH-1:0]   hold_q, hold_n;
  logic [CH_W-1:0]         cur_ch_q, cur_ch_n;
  logic [CH_W-1:0]         rr_ptr_q, rr_ptr_n;
  logic [15:0]             frame_q, frame_n;

  logic [DATA_WIDTH-1:0]   req_arr [NUM_CH];
  logic [CH_W-1:0]         win;
  logic                    found;
  logic [CH_W:0]           scan;
  logic                    tx_xfer;

  // Unpack the flat request bus into one byte per channel
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      req_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search: first valid channel starting at rr_ptr, wrapping mod NUM_CH
  always_comb begin
    win   = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (scan >= NUM_CH_V) begin
        scan = scan - NUM_CH_V;
      end
      if (!found && req_valid[scan[CH_W-1:0]]) begin
        found = 1'b1;
        win   = scan[CH_W-1:0];
      end
    end
  end

  assign tx_xfer = tx_valid_q && tx_ready;

  // Next-state and next-output logic for the grant/tag/payload sequence
  always_comb begin
    state_n    = state_q;
    tx_valid_n = tx_valid_q;
    tx_data_n  = tx_data_q;
    hold_n     = hold_q;
    cur_ch_n   = cur_ch_q;
    rr_ptr_n   = rr_ptr_q;
    frame_n    = frame_q;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          hold_n         = req_arr[win];
          cur_ch_n       = win;
          tx_valid_n     = 1'b1;
          if (TAG_EN) begin
            tx_data_n = TAG_BASE | DATA_WIDTH'(win);
            state_n   = TAG;
          end else begin
            tx_data_n = req_arr[win];
            state_n   = DATA;
          end
        end
      end
      TAG: begin
        if (tx_xfer) begin
          tx_data_n = hold_q;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (tx_xfer) begin
          tx_valid_n = 1'b0;
          frame_n    = frame_q + 16'd1;
          rr_ptr_n   = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
          state_n    = IDLE;
        end
      end
      default: begin
        state_n    = IDLE;
        tx_valid_n = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      hold_q     <= '0;
      cur_ch_q   <= '0;
      rr_ptr_q   <= '0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_n;
      tx_valid_q <= tx_valid_n;
      tx_data_q  <= tx_data_n;
      hold_q     <= hold_n;
      cur_ch_q   <= cur_ch_n;
      rr_ptr_q   <= rr_ptr_n;
      frame_q    <= frame_n;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != IDLE);
  assign cur_ch    = cur_ch_q;
  assign frame_cnt = frame_q;

endmodule
